// File: rtl/isram_arb.sv
// Instruction-SRAM arbiter: one SRAM port shared between a fetch read port and an
// external read/write port, with anti-starvation for ext and a bounded bus lock.
module isram_arb #(
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        fet_cs,
    input  logic [31:3] fet_adr,
    output logic        fet_stall_arb,
    output logic [63:0] fet_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_lock,
    input  logic [31:3] ext_adr,
    input  logic [63:0] ext_wdata,
    input  logic [7:0]  ext_wmask,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [63:0] ext_rdata,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [31:3] sram_adr,
    output logic [63:0] sram_wdata,
    output logic [7:0]  sram_wmask,
    input  logic [63:0] sram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

    typedef enum logic {
        ST_FET,
        ST_EXT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FET,
        OWN_EXT
    } owner_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_nxt;
    logic [LW-1:0] r_lock_cnt;
    logic [LW-1:0] w_lock_nxt;
    owner_t        r_rd_owner;
    owner_t        w_rd_owner_nxt;
    logic [63:0]   r_fet_hold;
    logic          w_fet_win;
    logic          w_ext_win;

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_fet_win = 1'b0;
        w_ext_win = 1'b0;
        case (r_state)
            ST_FET: begin
                if (fet_cs && (r_starve_cnt < STARVE_LIM)) begin
                    w_fet_win = 1'b1;
                end else if (ext_req) begin
                    w_ext_win = 1'b1;
                end
            end
            ST_EXT: begin
                if (ext_req) begin
                    w_ext_win = 1'b1;
                end else if (fet_cs) begin
                    w_fet_win = 1'b1;
                end
            end
        endcase
    end

    // lock_cnt counts ext grants in the current lock window, the entry grant
    // included; the grant that brings it to LOCK_MAX is the last one held.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_cnt;
        case (r_state)
            ST_FET: begin
                if (w_ext_win && ext_lock && (LOCK_MAX > 1)) begin
                    w_state_nxt = ST_EXT;
                    w_lock_nxt  = LW'(1);
                end
            end
            ST_EXT: begin
                if (w_ext_win) begin
                    w_lock_nxt = r_lock_cnt + 1'b1;
                end
                if (!ext_lock || !ext_req || (w_ext_win && (r_lock_cnt == LOCK_LAST))) begin
                    w_state_nxt = ST_FET;
                    w_lock_nxt  = '0;
                end
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!ext_req || w_ext_win) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != STARVE_LIM) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_fet_win) begin
            w_rd_owner_nxt = OWN_FET;
        end else if (w_ext_win && !ext_we) begin
            w_rd_owner_nxt = OWN_EXT;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge cpurst) begin
        if (!cpurst) begin
            r_state      <= ST_FET;
            r_starve_cnt <= '0;
            r_lock_cnt   <= '0;
            r_rd_owner   <= OWN_NONE;
            r_fet_hold   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_lock_cnt   <= w_lock_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
            if (r_rd_owner == OWN_FET) begin
                r_fet_hold <= sram_rdata;
            end
        end
    end

    assign sram_cs       = w_fet_win | w_ext_win;
    assign sram_we       = w_ext_win & ext_we;
    assign sram_adr      = w_ext_win ? ext_adr : fet_adr;
    assign sram_wdata    = w_ext_win ? ext_wdata : '0;
    assign sram_wmask    = w_ext_win ? ext_wmask : '0;
    assign fet_stall_arb = fet_cs & ~w_fet_win;
    assign ext_gnt       = w_ext_win;

    assign ext_rvalid = (r_rd_owner == OWN_EXT);
    assign ext_rdata  = ext_rvalid ? sram_rdata : '0;
    assign fet_rdata  = (r_rd_owner == OWN_FET) ? sram_rdata : r_fet_hold;

endmodule

// File: tb/tb_isram_arb.sv
// Bench for isram_arb: a table of arbitration vectors, directed corner sequences and
// random traffic, all checked against a cycle-level model of the arbitration rules.
module tb_isram_arb;

    localparam int STARVE_MAX = 4;
    localparam int LOCK_MAX   = 8;

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic        fet_cs = 1'b0;
    logic [31:3] fet_adr = '0;
    logic        fet_stall_arb;
    logic [63:0] fet_rdata;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic        ext_lock = 1'b0;
    logic [31:3] ext_adr = '0;
    logic [63:0] ext_wdata = '0;
    logic [7:0]  ext_wmask = '0;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [63:0] ext_rdata;
    logic        sram_cs;
    logic        sram_we;
    logic [31:3] sram_adr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_wmask;
    logic [63:0] sram_rdata = '0;

    isram_arb #(.STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .cpurst(cpurst),
        .fet_cs(fet_cs), .fet_adr(fet_adr), .fet_stall_arb(fet_stall_arb), .fet_rdata(fet_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_adr(ext_adr),
        .ext_wdata(ext_wdata), .ext_wmask(ext_wmask), .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_adr(sram_adr), .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM stand-in: 16 doublewords, read data one cycle after cs, junk otherwise.
    logic [63:0] sram_mem [16];
    always @(posedge clk) begin
        if (sram_cs && !sram_we) begin
            sram_rdata <= sram_mem[sram_adr[6:3]];
        end else begin
            sram_rdata <= {$urandom, $urandom};
        end
        if (sram_cs && sram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_wmask[b]) sram_mem[sram_adr[6:3]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ext priority flag, starvation and lock counts as integers,
    // plus the pending read return and its expected data.
    bit          m_ext_pri;
    int          m_starve;
    int          m_lock;
    int          m_prev;      // 0 none, 1 fetch read, 2 ext read
    logic [63:0] m_prev_data;
    logic [63:0] m_hold;
    logic [63:0] ref_mem [16];

    task automatic cycle(input logic f_cs, input logic [31:3] f_adr, input logic e_req,
                         input logic e_we, input logic e_lock, input logic [31:3] e_adr,
                         input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                         output logic a_stall, output logic a_gnt, output logic a_cs,
                         output logic a_we, output logic [7:0] a_wmask, output bit x_ext);
        bit fw, ew;
        fet_cs = f_cs; fet_adr = f_adr; ext_req = e_req; ext_we = e_we; ext_lock = e_lock;
        ext_adr = e_adr; ext_wdata = e_wdata; ext_wmask = e_wmask;
        #4;
        if (!m_ext_pri) begin
            fw = f_cs && (m_starve < STARVE_MAX);
            ew = !fw && e_req;
        end else begin
            ew = e_req;
            fw = !e_req && f_cs;
        end
        check("fet_stall_arb", 64'(fet_stall_arb), 64'(f_cs && !fw));
        check("ext_gnt", 64'(ext_gnt), 64'(ew));
        check("sram_cs", 64'(sram_cs), 64'(fw || ew));
        if (fw || ew) check("sram_adr", 64'(sram_adr), ew ? 64'(e_adr) : 64'(f_adr));
        check("sram_we", 64'(sram_we), 64'(ew && e_we));
        check("sram_wdata", sram_wdata, ew ? e_wdata : 64'd0);
        check("sram_wmask", 64'(sram_wmask), ew ? 64'(e_wmask) : 64'd0);
        check("ext_rvalid", 64'(ext_rvalid), 64'(m_prev == 2));
        check("ext_rdata", ext_rdata, (m_prev == 2) ? m_prev_data : 64'd0);
        check("fet_rdata", fet_rdata, (m_prev == 1) ? m_prev_data : m_hold);
        a_stall = fet_stall_arb; a_gnt = ext_gnt; a_cs = sram_cs; a_we = sram_we;
        a_wmask = sram_wmask; x_ext = ew;

        if (m_prev == 1) m_hold = m_prev_data;
        if (fw) begin
            m_prev = 1; m_prev_data = ref_mem[f_adr[6:3]];
        end else if (ew && !e_we) begin
            m_prev = 2; m_prev_data = ref_mem[e_adr[6:3]];
        end else begin
            m_prev = 0;
        end
        if (ew && e_we) begin
            for (int b = 0; b < 8; b++) begin
                if (e_wmask[b]) ref_mem[e_adr[6:3]][8*b +: 8] = e_wdata[8*b +: 8];
            end
        end
        if (!e_req || ew) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (!m_ext_pri) begin
            if (ew && e_lock) begin m_ext_pri = 1; m_lock = 1; end
        end else begin
            if (ew) m_lock++;
            if (!e_lock || !e_req || (ew && m_lock == LOCK_MAX)) begin
                m_ext_pri = 0; m_lock = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cpurst = 1'b0;
        fet_cs = 1'b1; ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0;
        #1;
        check("rst_sram_cs", 64'(sram_cs), 64'd1);
        check("rst_stall", 64'(fet_stall_arb), 64'd0);
        fet_cs = 1'b0;
        #1;
        check("rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
        check("rst_ext_rdata", ext_rdata, 64'd0);
        check("rst_fet_rdata", fet_rdata, 64'd0);
        @(posedge clk);
        #1;
        cpurst = 1'b1;
        m_ext_pri = 0; m_starve = 0; m_lock = 0; m_prev = 0; m_prev_data = '0; m_hold = '0;
    endtask

    typedef struct {
        logic       f_cs, e_req, e_we;
        logic [7:0] e_wmask;
        logic       x_stall, x_gnt, x_cs, x_we;
        logic [7:0] x_wmask;
    } vec_t;

    initial begin
        vec_t        vecs [11];
        logic        a_stall, a_gnt, a_cs, a_we;
        logic [7:0]  a_wmask;
        bit          x_ext;
        int          run, best;
        logic        p_req, p_we, p_lock;
        logic [31:3] p_adr;
        logic [63:0] p_wd;
        logic [7:0]  p_wm;
        bit          pending;
        logic [31:3] fa;
        logic [31:3] ea;

        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = {32'hA5A5_0000 + 32'(i), ~32'(i * 7)};
            ref_mem[i]  = {32'hA5A5_0000 + 32'(i), ~32'(i * 7)};
        end
        #1;
        do_reset();

        // From reset: write, four starved ext reads, the fifth wins, then idle.
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00};
        vecs[1]  = '{0, 1, 1, 8'h0F, 0, 1, 1, 1, 8'h0F};
        vecs[2]  = '{1, 1, 0, 8'hFF, 0, 0, 1, 0, 8'h00};
        vecs[3]  = '{1, 1, 0, 8'hFF, 0, 0, 1, 0, 8'h00};
        vecs[4]  = '{1, 1, 0, 8'hFF, 0, 0, 1, 0, 8'h00};
        vecs[5]  = '{1, 1, 0, 8'hFF, 0, 0, 1, 0, 8'h00};
        vecs[6]  = '{1, 1, 0, 8'hFF, 1, 1, 1, 0, 8'hFF};
        vecs[7]  = '{1, 1, 0, 8'hFF, 0, 0, 1, 0, 8'h00};
        vecs[8]  = '{0, 1, 0, 8'hFF, 0, 1, 1, 0, 8'hFF};
        vecs[9]  = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00};
        vecs[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00};
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].f_cs, 29'h20, vecs[i].e_req, vecs[i].e_we, 1'b0, 29'h5,
                  64'hDEADBEEF_CAFEF00D, vecs[i].e_wmask, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
            check($sformatf("vec%0d_stall", i), 64'(a_stall), 64'(vecs[i].x_stall));
            check($sformatf("vec%0d_gnt", i), 64'(a_gnt), 64'(vecs[i].x_gnt));
            check($sformatf("vec%0d_cs", i), 64'(a_cs), 64'(vecs[i].x_cs));
            check($sformatf("vec%0d_we", i), 64'(a_we), 64'(vecs[i].x_we));
            check($sformatf("vec%0d_wmask", i), 64'(a_wmask), 64'(vecs[i].x_wmask));
        end

        // Continuous fetch stream.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 29'h20, 1'b0, 1'b0, 1'b0, '0, '0, '0, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
        end

        // Locked ext burst against continuous fetch: 4 fetches, 8 ext grants, fetch again.
        do_reset();
        run = 0; best = 0;
        for (int i = 0; i < 12; i++) begin
            ea = 29'(i + 2);
            cycle(1'b1, 29'h20, 1'b1, 1'b0, 1'b1, ea, '0, 8'hFF, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
            run  = a_gnt ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        check("lock_burst_len", 64'(best), 64'(LOCK_MAX));
        cycle(1'b1, 29'h21, 1'b1, 1'b0, 1'b1, 29'h3, '0, 8'hFF, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
        check("lock_exit_fetch", 64'(a_stall), 64'd0);

        // Reset between a fetch read and a locked ext read discards both returns.
        do_reset();
        cycle(1'b1, 29'h22, 1'b0, 1'b0, 1'b0, '0, '0, '0, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
        cycle(1'b0, 29'h22, 1'b1, 1'b0, 1'b1, 29'h6, '0, 8'hFF, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
        check("pre_rst_ext_gnt", 64'(a_gnt), 64'd1);
        do_reset();
        cycle(1'b1, 29'h23, 1'b1, 1'b0, 1'b1, 29'h7, '0, 8'hFF, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
        check("post_rst_fet_first", 64'(a_stall), 64'd0);
        cycle(1'b0, 29'h23, 1'b1, 1'b0, 1'b0, 29'h7, '0, 8'hFF, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);

        // Alternating fetch / ext reads, one access per cycle.
        for (int i = 0; i < 10; i++) begin
            fa = 29'(i);
            ea = 29'(i + 8);
            if (i % 2 == 0)
                cycle(1'b1, fa, 1'b0, 1'b0, 1'b0, ea, '0, '0, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
            else
                cycle(1'b0, fa, 1'b1, 1'b0, 1'b0, ea, '0, '0, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
            check($sformatf("alt%0d_cs", i), 64'(a_cs), 64'd1);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);

        // Random traffic; an ungranted ext request keeps its fields until granted.
        pending = 0;
        p_req = 0; p_we = 0; p_lock = 0; p_adr = '0; p_wd = '0; p_wm = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                pending = 0;
            end
            if (!pending) begin
                p_req  = ($urandom_range(0, 2) != 0);
                p_we   = 1'($urandom_range(0, 1));
                p_lock = ($urandom_range(0, 2) == 0);
                p_adr  = 29'($urandom);
                p_wd   = {$urandom, $urandom};
                p_wm   = 8'($urandom);
            end
            fa = 29'($urandom);
            cycle(($urandom_range(0, 3) != 0), fa, p_req, p_we, p_lock, p_adr, p_wd, p_wm,
                  a_stall, a_gnt, a_cs, a_we, a_wmask, x_ext);
            pending = p_req && !x_ext;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/isram_arb.md
ISRAM_ARB -- requirements
Module: isram_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive cycles a pending ext request may lose to fetch.
REQ-002 Parameter LOCK_MAX, default 8: max consecutive ext grants held under ext_lock.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 cpurst  input  1  reset, asynchronous, active-low.
REQ-005 fet_cs  input  1  fetch read request this cycle.
REQ-006 fet_adr  input  [31:3]  fetch doubleword address.
REQ-007 fet_stall_arb  output  1  fetch request not granted this cycle.
REQ-008 fet_rdata  output  64  fetch read data.
REQ-009 ext_req, ext_we, ext_lock  input  1 each  ext request, write enable, hold-bus hint.
REQ-010 ext_adr  input  [31:3]; ext_wdata  input  64; ext_wmask  input  8 (byte enables).
REQ-011 ext_gnt  output  1  ext request accepted this cycle.
REQ-012 ext_rvalid  output  1; ext_rdata  output  64  ext read return.
REQ-013 sram_cs, sram_we  output  1; sram_adr  output  [31:3]; sram_wdata  output  64; sram_wmask  output  8.
REQ-014 sram_rdata  input  64  valid exactly one cycle after a read cs.

Function
REQ-015 FSM states: FET (fetch priority), EXT (ext priority, lock held).
REQ-016 In FET: grant fetch if fet_cs and starve_cnt < STARVE_MAX; else grant ext if ext_req.
REQ-017 In EXT: grant ext if ext_req; else grant fetch if fet_cs.
REQ-018 Grant decision combinational same cycle; at most one grant per cycle.
REQ-019 sram_cs = any grant; sram_adr/we/wdata/wmask muxed from winner; sram_we = 0 on fetch grant; sram_wdata/wmask = 0 when not ext grant.
REQ-020 fet_stall_arb = fet_cs AND NOT fetch-granted.
REQ-021 ext_gnt = ext granted; ext must hold request fields stable until ext_gnt.
REQ-022 starve_cnt (clog2(STARVE_MAX+1) bits): +1 each cycle ext_req and not ext_gnt, saturating at STARVE_MAX; cleared on ext_gnt or ext_req = 0.
REQ-023 FET->EXT on ext_gnt with ext_lock = 1; lock_cnt loaded with 1.
REQ-024 In EXT: lock_cnt +1 per ext_gnt; EXT->FET when ext_lock = 0, ext_req = 0, or grant occurs with lock_cnt = LOCK_MAX.
REQ-025 EXT->FET transition takes effect next cycle; fetch then granted even if starve_cnt non-zero only below STARVE_MAX per REQ-016.
REQ-026 rd_owner register: set each cycle to {fetch read, ext read, none} of the current grant.
REQ-027 ext_rvalid = 1 one cycle after ext read grant (ext_gnt and not ext_we); ext_rdata = sram_rdata then, else 0.
REQ-028 Writes return no ext_rvalid.
REQ-029 fet_rdata = sram_rdata when rd_owner = fetch; otherwise holds last fetch-returned value (fet_hold register).
REQ-030 Back-to-back grants to alternating owners sustain one access per cycle; no bubble inserted.
REQ-031 Simultaneous fet_cs and ext_req with starve_cnt = STARVE_MAX in FET: ext wins, starve_cnt cleared.

Reset
REQ-032 On cpurst low: state FET, starve_cnt 0, lock_cnt 0, rd_owner none, fet_hold 0, ext_rvalid 0, ext_rdata 0, fet_rdata 0.
REQ-033 Combinational outputs during reset follow REQ-016..REQ-020 from reset state; any in-flight read return is discarded.
REQ-034 Reset deassertion effective on next rising edge; no request lost other than those in flight.

Verification
REQ-035 fet_cs=1 continuous, ext_req=0, fet_adr 0x100>>3 -> sram_cs=1 every cycle, fet_stall_arb=0, fet_rdata=sram_rdata one cycle later.
REQ-036 fet_cs=1 and ext_req=1 (read, ext_lock=0) continuous -> ext_gnt asserted on 5th cycle (STARVE_MAX=4), fet_stall_arb=1 that cycle only, ext_rvalid=1 next cycle with ext_rdata=sram_rdata.
REQ-037 fet_cs=0, ext_req=1, ext_we=1, ext_wmask=0x0F, ext_wdata=0xDEADBEEF_CAFEF00D -> same cycle sram_we=1, sram_wmask=0x0F, no ext_rvalid.
REQ-038 ext_lock=1, ext_req=1 for 12 cycles, fet_cs=1 -> 8 consecutive ext grants, then return to FET and fetch granted next cycle.
REQ-039 Fetch read granted then ext read granted, cpurst pulsed low between -> ext_rvalid=0, fet_rdata=0, state FET after release.
REQ-040 Alternating fetch/ext reads each cycle -> fet_rdata updates only after fetch cycles, holds value across ext return cycles.
